spi_target: RTL and testbench

- SPI mode-0 target (slave). It is the far end of the tk1 SPI master: it receives bytes on MOSI and returns bytes on MISO.
- Sits in the board-level test harness and in a secondary FPGA/co-processor image, letting firmware SPI traffic be exercised against real RTL instead of an external flash.
- SPI pins are oversampled in the clk domain.
- Byte streams are exchanged with local logic over valid/ready handshakes.

---
 rtl/spi_target_pkg.sv | 14 +
 rtl/spi_target_sync.sv | 34 +++
 rtl/spi_target.sv | 151 +++++++++++++++
 tb/tb_spi_target.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_target_pkg.sv
// Shared types and constants for the SPI mode-0 target.
// Imported by the synchronizer and the top-level FSM.
package spi_target_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    localparam int SPI_BITS = 8;
    localparam int CTR_W = $clog2(SPI_BITS);
    localparam logic [SPI_BITS-1:0] DEFAULT_DUMMY = 8'hff;

endpackage

// File: rtl/spi_target_sync.sv
// Two-flop synchronizer plus a third flop for edge detection.
// Level, rise and fall are all derived from the synchronized value.
module spi_target_sync
    import spi_target_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic s1;
    logic s2;
    logic s3;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= din;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign level = s2;
    assign rise  = s2 & ~s3;
    assign fall  = ~s2 & s3;

endmodule

// File: rtl/spi_target.sv
// SPI mode-0 target: oversampled pins, byte shifters and
// valid/ready byte streams toward local logic.
module spi_target
    import spi_target_pkg::*;
#(
    parameter logic [SPI_BITS-1:0] DUMMY_BYTE = DEFAULT_DUMMY
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                spi_cs,
    input  logic                spi_clk,
    input  logic                spi_mosi,
    output logic                spi_miso,
    output logic                spi_miso_oe,
    output logic [SPI_BITS-1:0] rx_data,
    output logic                rx_valid,
    input  logic                rx_ready,
    input  logic [SPI_BITS-1:0] tx_data,
    input  logic                tx_valid,
    output logic                tx_ready,
    output logic                rx_overrun,
    output logic                tx_underrun,
    input  logic                status_clr,
    output logic                active
);

    state_t              state;
    logic [CTR_W-1:0]    bit_ctr;
    logic [SPI_BITS-1:0] rx_shift;
    logic [SPI_BITS-1:0] tx_shift;

    logic cs_lvl, cs_rise, cs_fall;
    logic sclk_lvl, sclk_rise, sclk_fall;
    logic mosi_s, mosi_rise, mosi_fall;
    logic unused_sync;

    logic [SPI_BITS-1:0] next_tx;
    logic [SPI_BITS-1:0] rx_next;
    logic                last_bit;

    spi_target_sync u_cs (
        .clk   (clk),
        .reset (reset),
        .din   (spi_cs),
        .level (cs_lvl),
        .rise  (cs_rise),
        .fall  (cs_fall)
    );

    spi_target_sync u_sclk (
        .clk   (clk),
        .reset (reset),
        .din   (spi_clk),
        .level (sclk_lvl),
        .rise  (sclk_rise),
        .fall  (sclk_fall)
    );

    spi_target_sync u_mosi (
        .clk   (clk),
        .reset (reset),
        .din   (spi_mosi),
        .level (mosi_s),
        .rise  (mosi_rise),
        .fall  (mosi_fall)
    );

    assign unused_sync = ^{cs_lvl, sclk_lvl, mosi_rise, mosi_fall};

    assign next_tx  = tx_valid ? tx_data : DUMMY_BYTE;
    assign rx_next  = {rx_shift[SPI_BITS-2:0], mosi_s};
    assign last_bit = (bit_ctr == CTR_W'(SPI_BITS - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            bit_ctr     <= '0;
            rx_shift    <= '0;
            tx_shift    <= '0;
            spi_miso    <= 1'b0;
            spi_miso_oe <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            tx_ready    <= 1'b0;
            rx_overrun  <= 1'b0;
            tx_underrun <= 1'b0;
            active      <= 1'b0;
        end else begin
            tx_ready <= 1'b0;
            if (rx_valid && rx_ready)
                rx_valid <= 1'b0;
            // Flag sets below override this clear.
            if (status_clr) begin
                rx_overrun  <= 1'b0;
                tx_underrun <= 1'b0;
            end
            unique case (state)
                IDLE: begin
                    if (cs_fall) begin
                        state       <= ACTIVE;
                        bit_ctr     <= '0;
                        rx_shift    <= '0;
                        active      <= 1'b1;
                        spi_miso_oe <= 1'b1;
                        tx_shift    <= next_tx;
                        spi_miso    <= next_tx[SPI_BITS-1];
                        if (tx_valid)
                            tx_ready <= 1'b1;
                        else
                            tx_underrun <= 1'b1;
                    end
                end
                ACTIVE: begin
                    if (cs_rise) begin
                        state       <= IDLE;
                        bit_ctr     <= '0;
                        rx_shift    <= '0;
                        active      <= 1'b0;
                        spi_miso_oe <= 1'b0;
                        spi_miso    <= 1'b0;
                    end else if (sclk_rise) begin
                        rx_shift <= rx_next;
                        bit_ctr  <= bit_ctr + 1'b1;
                        if (last_bit) begin
                            if (!rx_valid || rx_ready) begin
                                rx_data  <= rx_next;
                                rx_valid <= 1'b1;
                            end else begin
                                rx_overrun <= 1'b1;
                            end
                        end
                    end else if (sclk_fall) begin
                        // Counter wrapped to zero: byte boundary.
                        if (bit_ctr == '0) begin
                            tx_shift <= next_tx;
                            spi_miso <= next_tx[SPI_BITS-1];
                            if (tx_valid)
                                tx_ready <= 1'b1;
                            else
                                tx_underrun <= 1'b1;
                        end else begin
                            tx_shift <= tx_shift << 1;
                            spi_miso <= tx_shift[SPI_BITS-2];
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_target.sv
// Directed bench for spi_target: bit-banged SPI master,
// tx feeder and rx collector running on the falling clk edge.
module tb_spi_target;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       spi_cs = 1'b1;
    logic       spi_clk = 1'b0;
    logic       spi_mosi = 1'b0;
    logic       spi_miso;
    logic       spi_miso_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       rx_overrun;
    logic       tx_underrun;
    logic       status_clr = 1'b0;
    logic       active;

    int tests = 0;
    int fails = 0;
    int pulses = 0;
    int ready_mode = 1;
    bit rand_valid = 1'b0;
    logic [7:0] txq[$];
    logic [7:0] sentq[$];
    logic [7:0] rxq[$];

    spi_target dut (
        .clk         (clk),
        .reset       (reset),
        .spi_cs      (spi_cs),
        .spi_clk     (spi_clk),
        .spi_mosi    (spi_mosi),
        .spi_miso    (spi_miso),
        .spi_miso_oe (spi_miso_oe),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .rx_overrun  (rx_overrun),
        .tx_underrun (tx_underrun),
        .status_clr  (status_clr),
        .active      (active)
    );

    always #5 clk = ~clk;

    // Local-side model: feeds tx bytes, records accepted rx bytes.
    always @(negedge clk) begin
        if (tx_ready) begin
            pulses++;
            if (txq.size() > 0)
                sentq.push_back(txq.pop_front());
        end
        tx_data  = (txq.size() > 0) ? txq[0] : 8'h00;
        tx_valid = (txq.size() > 0) &&
                   (!rand_valid || $urandom_range(0, 1) == 1);
        case (ready_mode)
            0: rx_ready = 1'b0;
            1: rx_ready = 1'b1;
            default: rx_ready = 1'($urandom_range(0, 1));
        endcase
        if (rx_valid && rx_ready)
            rxq.push_back(rx_data);
    end

    task automatic cs_assert();
        spi_cs = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic cs_release(input int half);
        repeat (half) @(negedge clk);
        spi_cs = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic spi_bits(input logic [7:0] mo, input int n,
                            input int half, output logic [7:0] mi);
        mi = 8'h00;
        for (int i = 0; i < n; i++) begin
            spi_mosi = mo[7-i];
            repeat (half) @(negedge clk);
            mi[7-i] = spi_miso;
            spi_clk = 1'b1;
            repeat (half) @(negedge clk);
            spi_clk = 1'b0;
        end
    endtask

    task automatic clear_status();
        status_clr = 1'b1;
        @(negedge clk);
        status_clr = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        tests++;
        if ({spi_miso, spi_miso_oe, rx_data, rx_valid, tx_ready,
             rx_overrun, tx_underrun, active} !== 15'h0) begin
            fails++;
            $display("FAIL reset_state: got %h required 0",
                     {spi_miso, spi_miso_oe, rx_data, rx_valid,
                      tx_ready, rx_overrun, tx_underrun, active});
        end
        reset = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_single_byte();
        logic [7:0] mi;
        rxq.delete();
        txq.push_back(8'ha5);
        pulses = 0;
        repeat (10) @(negedge clk);
        tests++;
        if (pulses !== 0) begin
            fails++;
            $display("FAIL idle_tx_ready: got %0d pulses required 0",
                     pulses);
        end
        cs_assert();
        tests++;
        if (active !== 1'b1 || spi_miso_oe !== 1'b1) begin
            fails++;
            $display("FAIL cs_active: got %b%b required 11",
                     active, spi_miso_oe);
        end
        spi_bits(8'h3c, 8, 4, mi);
        cs_release(4);
        tests++;
        if (mi !== 8'ha5) begin
            fails++;
            $display("FAIL single_miso: got %h required a5", mi);
        end
        tests++;
        if (rxq.size() != 1 || rxq[0] !== 8'h3c) begin
            fails++;
            $display("FAIL single_rx: got %0d bytes first %h required 3c",
                     rxq.size(), (rxq.size() > 0) ? rxq[0] : 8'hxx);
        end
        tests++;
        if (pulses !== 1) begin
            fails++;
            $display("FAIL single_tx_ready: got %0d pulses required 1",
                     pulses);
        end
        clear_status();
    endtask

    task automatic test_back_to_back();
        logic [7:0] mo[3];
        logic [7:0] exp_mi[3];
        logic [7:0] mi[3];
        mo = '{8'h01, 8'h02, 8'h03};
        exp_mi = '{8'h10, 8'h20, 8'hff};
        rxq.delete();
        txq.push_back(8'h10);
        txq.push_back(8'h20);
        pulses = 0;
        @(negedge clk);
        cs_assert();
        for (int b = 0; b < 3; b++) begin
            spi_bits(mo[b], 8, 4, mi[b]);
            if (b == 0) begin
                tests++;
                if (tx_underrun !== 1'b0) begin
                    fails++;
                    $display("FAIL b2b_underrun_early: got %b required 0",
                             tx_underrun);
                end
            end
        end
        cs_release(4);
        for (int b = 0; b < 3; b++) begin
            tests++;
            if (mi[b] !== exp_mi[b]) begin
                fails++;
                $display("FAIL b2b_miso[%0d]: got %h required %h",
                         b, mi[b], exp_mi[b]);
            end
            tests++;
            if (rxq.size() <= b || rxq[b] !== mo[b]) begin
                fails++;
                $display("FAIL b2b_rx[%0d]: got %h required %h", b,
                         (rxq.size() > b) ? rxq[b] : 8'hxx, mo[b]);
            end
        end
        tests++;
        if (tx_underrun !== 1'b1) begin
            fails++;
            $display("FAIL b2b_underrun: got %b required 1", tx_underrun);
        end
        tests++;
        if (pulses !== 2) begin
            fails++;
            $display("FAIL b2b_tx_ready: got %0d pulses required 2", pulses);
        end
        clear_status();
    endtask

    task automatic test_overrun();
        logic [7:0] mi;
        ready_mode = 0;
        rxq.delete();
        @(negedge clk);
        cs_assert();
        spi_bits(8'h11, 8, 4, mi);
        spi_bits(8'h22, 8, 4, mi);
        cs_release(4);
        tests++;
        if (rx_data !== 8'h11 || rx_valid !== 1'b1) begin
            fails++;
            $display("FAIL ovr_rx: got %h/%b required 11/1",
                     rx_data, rx_valid);
        end
        tests++;
        if (rx_overrun !== 1'b1) begin
            fails++;
            $display("FAIL ovr_flag: got %b required 1", rx_overrun);
        end
        clear_status();
        tests++;
        if (rx_overrun !== 1'b0 || tx_underrun !== 1'b0) begin
            fails++;
            $display("FAIL ovr_clear: got %b%b required 00",
                     rx_overrun, tx_underrun);
        end
        ready_mode = 1;
        repeat (3) @(negedge clk);
        tests++;
        if (rx_valid !== 1'b0 || rxq.size() != 1) begin
            fails++;
            $display("FAIL ovr_accept: got valid %b count %0d required 0/1",
                     rx_valid, rxq.size());
        end
        rxq.delete();
    endtask

    task automatic test_abort();
        logic [7:0] mi;
        rxq.delete();
        cs_assert();
        spi_bits(8'hc3, 5, 4, mi);
        cs_release(4);
        tests++;
        if (rxq.size() != 0 || rx_valid !== 1'b0) begin
            fails++;
            $display("FAIL abort_rx: got count %0d valid %b required 0/0",
                     rxq.size(), rx_valid);
        end
        tests++;
        if (spi_miso_oe !== 1'b0 || active !== 1'b0 || spi_miso !== 1'b0) begin
            fails++;
            $display("FAIL abort_pins: got oe %b act %b miso %b required 000",
                     spi_miso_oe, active, spi_miso);
        end
        txq.push_back(8'h9c);
        @(negedge clk);
        cs_assert();
        spi_bits(8'h77, 8, 4, mi);
        cs_release(4);
        tests++;
        if (rxq.size() != 1 || rxq[0] !== 8'h77) begin
            fails++;
            $display("FAIL abort_realign_rx: got %0d bytes first %h required 77",
                     rxq.size(), (rxq.size() > 0) ? rxq[0] : 8'hxx);
        end
        tests++;
        if (mi !== 8'h9c) begin
            fails++;
            $display("FAIL abort_realign_miso: got %h required 9c", mi);
        end
        clear_status();
    endtask

    task automatic test_async_reset();
        logic [7:0] mi;
        rxq.delete();
        txq.push_back(8'he1);
        @(negedge clk);
        cs_assert();
        spi_bits(8'hf0, 4, 4, mi);
        spi_clk = 1'b1;
        #3;
        reset = 1'b1;
        #1;
        tests++;
        if ({spi_miso, spi_miso_oe, rx_data, rx_valid, tx_ready,
             rx_overrun, tx_underrun, active} !== 15'h0) begin
            fails++;
            $display("FAIL async_reset: got %h required 0",
                     {spi_miso, spi_miso_oe, rx_data, rx_valid,
                      tx_ready, rx_overrun, tx_underrun, active});
        end
        for (int i = 0; i < 4; i++) begin
            repeat (2) @(negedge clk);
            spi_clk = ~spi_clk;
        end
        spi_cs = 1'b1;
        txq.delete();
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 16; i++) begin
            repeat (3) @(negedge clk);
            spi_clk = ~spi_clk;
        end
        spi_clk = 1'b0;
        repeat (6) @(negedge clk);
        tests++;
        if (active !== 1'b0 || spi_miso_oe !== 1'b0 || rx_valid !== 1'b0 ||
            rxq.size() != 0) begin
            fails++;
            $display("FAIL post_reset_idle: got act %b oe %b valid %b count %0d",
                     active, spi_miso_oe, rx_valid, rxq.size());
        end
        txq.push_back(8'h4b);
        @(negedge clk);
        cs_assert();
        spi_bits(8'h5a, 8, 4, mi);
        cs_release(4);
        tests++;
        if (mi !== 8'h4b || rxq.size() != 1 || rxq[0] !== 8'h5a) begin
            fails++;
            $display("FAIL post_reset_xfer: got miso %h rx %h required 4b/5a",
                     mi, (rxq.size() > 0) ? rxq[0] : 8'hxx);
        end
        clear_status();
    endtask

    task automatic test_speed_limit();
        logic [7:0] mo[24];
        logic [7:0] mi[24];
        logic [7:0] exp;
        rxq.delete();
        sentq.delete();
        for (int i = 0; i < 30; i++)
            txq.push_back(8'($urandom_range(0, 254)));
        for (int i = 0; i < 24; i++)
            mo[i] = 8'($urandom_range(0, 255));
        rand_valid = 1'b1;
        ready_mode = 2;
        @(negedge clk);
        cs_assert();
        for (int i = 0; i < 24; i++)
            spi_bits(mo[i], 8, 3, mi[i]);
        cs_release(3);
        ready_mode = 1;
        repeat (4) @(negedge clk);
        rand_valid = 1'b0;
        tests++;
        if (rxq.size() != 24) begin
            fails++;
            $display("FAIL speed_rx_count: got %0d required 24", rxq.size());
        end
        for (int i = 0; i < 24; i++) begin
            tests++;
            if (rxq.size() <= i || rxq[i] !== mo[i]) begin
                fails++;
                $display("FAIL speed_rx[%0d]: got %h required %h", i,
                         (rxq.size() > i) ? rxq[i] : 8'hxx, mo[i]);
            end
            if (mi[i] !== 8'hff) begin
                exp = (sentq.size() > 0) ? sentq.pop_front() : 8'hxx;
                tests++;
                if (mi[i] !== exp) begin
                    fails++;
                    $display("FAIL speed_miso[%0d]: got %h required %h",
                             i, mi[i], exp);
                end
            end
        end
        tests++;
        if (rx_overrun !== 1'b0) begin
            fails++;
            $display("FAIL speed_overrun: got %b required 0", rx_overrun);
        end
        txq.delete();
        clear_status();
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_overrun();
        test_abort();
        test_async_reset();
        test_speed_limit();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
